// File: rtl/ports_top_if.sv
// ----------------------------------------------------------------------------
// ports_top_if
// Purpose : bundles the SFR-side and pad-side signals of the MCU port block
//           (P0..P3 bidirectional, P4 output-only).
// Members :
//   ports_sfr_P0EN_i..P3EN_i  direction SFRs (1 = output, 0 = input)
//   ports_sfr_P0_i..P4_i      port data SFRs (value to drive)
//   ports_sfr_P0_o..P3_o      registered read-back to the SFR bus
//   y_port0_i..y_port3_i      asynchronous pad input levels
//   en_port0_o..en_port3_o    pad output enables, active-low
//   a_port0_o..a_port4_o      pad drive data
// Modports: master = SFR bank / pad ring side, slave = ports_top.
// ----------------------------------------------------------------------------
interface ports_top_if #(
    parameter int unsigned PORT_W = 8
);
    logic [PORT_W-1:0] ports_sfr_P0EN_i, ports_sfr_P1EN_i, ports_sfr_P2EN_i, ports_sfr_P3EN_i;
    logic [PORT_W-1:0] ports_sfr_P0_i, ports_sfr_P1_i, ports_sfr_P2_i, ports_sfr_P3_i;
    logic [PORT_W-1:0] ports_sfr_P4_i;
    logic [PORT_W-1:0] ports_sfr_P0_o, ports_sfr_P1_o, ports_sfr_P2_o, ports_sfr_P3_o;
    logic [PORT_W-1:0] y_port0_i, y_port1_i, y_port2_i, y_port3_i;
    logic [PORT_W-1:0] en_port0_o, en_port1_o, en_port2_o, en_port3_o;
    logic [PORT_W-1:0] a_port0_o, a_port1_o, a_port2_o, a_port3_o, a_port4_o;

    modport master (
        output ports_sfr_P0EN_i, ports_sfr_P1EN_i, ports_sfr_P2EN_i, ports_sfr_P3EN_i,
        output ports_sfr_P0_i, ports_sfr_P1_i, ports_sfr_P2_i, ports_sfr_P3_i, ports_sfr_P4_i,
        output y_port0_i, y_port1_i, y_port2_i, y_port3_i,
        input  ports_sfr_P0_o, ports_sfr_P1_o, ports_sfr_P2_o, ports_sfr_P3_o,
        input  en_port0_o, en_port1_o, en_port2_o, en_port3_o,
        input  a_port0_o, a_port1_o, a_port2_o, a_port3_o, a_port4_o
    );

    modport slave (
        input  ports_sfr_P0EN_i, ports_sfr_P1EN_i, ports_sfr_P2EN_i, ports_sfr_P3EN_i,
        input  ports_sfr_P0_i, ports_sfr_P1_i, ports_sfr_P2_i, ports_sfr_P3_i, ports_sfr_P4_i,
        input  y_port0_i, y_port1_i, y_port2_i, y_port3_i,
        output ports_sfr_P0_o, ports_sfr_P1_o, ports_sfr_P2_o, ports_sfr_P3_o,
        output en_port0_o, en_port1_o, en_port2_o, en_port3_o,
        output a_port0_o, a_port1_o, a_port2_o, a_port3_o, a_port4_o
    );
endinterface

// File: rtl/ports_top.sv
// ----------------------------------------------------------------------------
// ports_top
// Purpose : I/O port block of the 8-bit MCU. Maps the direction and data SFRs
//           onto pad controls and returns pad levels to the SFR read bus.
// Ports   :
//   ports_clk_i        system clock
//   ports_rst_i        synchronous active-high reset
//   ports_test_mode_i  1 = all pins forced to input, drive data forced to 0
//   bus                ports_top_if.slave (SFR and pad signals)
// Params  :
//   PORT_W  width of every port (must match the interface)
//   RST_EN  level of every enable bit while reset or test mode is active
// Config  :
//   PORTS_INSYNC_EN  adds a second synchroniser stage on every pad input;
//                    pad changes then reach the read-back after 2 edges.
// ----------------------------------------------------------------------------
module ports_top #(
    parameter int unsigned PORT_W = 8,
    parameter logic        RST_EN = 1'b1
) (
    input logic        ports_clk_i,
    input logic        ports_rst_i,
    input logic        ports_test_mode_i,
    ports_top_if.slave bus
);
    localparam int unsigned NPORT = 4;

    logic                         w_override;
    logic [NPORT-1:0][PORT_W-1:0] w_dir;
    logic [NPORT-1:0][PORT_W-1:0] w_dat;
    logic [NPORT-1:0][PORT_W-1:0] w_pad_in;
    logic [NPORT-1:0][PORT_W-1:0] w_pad;
    logic [NPORT-1:0][PORT_W-1:0] w_en;
    logic [NPORT-1:0][PORT_W-1:0] w_sel;
    logic [NPORT-1:0][PORT_W-1:0] r_rd;

    // Override gating is purely combinational so it tracks the inputs in-cycle.
    assign w_override = ports_rst_i | ports_test_mode_i;

    assign w_dir[0] = bus.ports_sfr_P0EN_i;
    assign w_dir[1] = bus.ports_sfr_P1EN_i;
    assign w_dir[2] = bus.ports_sfr_P2EN_i;
    assign w_dir[3] = bus.ports_sfr_P3EN_i;

    assign w_dat[0] = bus.ports_sfr_P0_i;
    assign w_dat[1] = bus.ports_sfr_P1_i;
    assign w_dat[2] = bus.ports_sfr_P2_i;
    assign w_dat[3] = bus.ports_sfr_P3_i;

    assign w_pad_in[0] = bus.y_port0_i;
    assign w_pad_in[1] = bus.y_port1_i;
    assign w_pad_in[2] = bus.y_port2_i;
    assign w_pad_in[3] = bus.y_port3_i;

`ifdef PORTS_INSYNC_EN
    logic [NPORT-1:0][PORT_W-1:0] r_sync;

    always_ff @(posedge ports_clk_i) begin
        if (ports_rst_i) begin
            r_sync <= '0;
        end else begin
            r_sync <= w_pad_in;
        end
    end

    assign w_pad = r_sync;
`else
    // The read-back register itself is the only sampling stage.
    assign w_pad = w_pad_in;
`endif

    // Identical per-port logic; an X on a direction bit stays confined to that bit.
    always_comb begin
        w_en  = '0;
        w_sel = '0;
        for (int p = 0; p < NPORT; p++) begin
            w_en[p]  = w_override ? {PORT_W{RST_EN}} : ~w_dir[p];
            w_sel[p] = (w_en[p] & w_pad[p]) | (~w_en[p] & w_dat[p]);
        end
    end

    always_ff @(posedge ports_clk_i) begin
        if (ports_rst_i) begin
            r_rd <= '0;
        end else begin
            r_rd <= w_sel;
        end
    end

    assign bus.en_port0_o = w_en[0];
    assign bus.en_port1_o = w_en[1];
    assign bus.en_port2_o = w_en[2];
    assign bus.en_port3_o = w_en[3];

    assign bus.a_port0_o = w_override ? '0 : w_dat[0];
    assign bus.a_port1_o = w_override ? '0 : w_dat[1];
    assign bus.a_port2_o = w_override ? '0 : w_dat[2];
    assign bus.a_port3_o = w_override ? '0 : w_dat[3];
    assign bus.a_port4_o = w_override ? '0 : bus.ports_sfr_P4_i;

    assign bus.ports_sfr_P0_o = r_rd[0];
    assign bus.ports_sfr_P1_o = r_rd[1];
    assign bus.ports_sfr_P2_o = r_rd[2];
    assign bus.ports_sfr_P3_o = r_rd[3];
endmodule

// File: tb/tb_ports_top.sv
// ----------------------------------------------------------------------------
// tb_ports_top
// Purpose : self-checking bench for ports_top. Table-driven vectors, directed
//           corner-case sequences and a randomized run against a reference
//           model of the port block.
// ----------------------------------------------------------------------------
module tb_ports_top;
    localparam int W = 8;
`ifdef PORTS_INSYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic clk = 1'b0;
    logic rst;
    logic tm;

    ports_top_if #(.PORT_W(W)) bus ();

    ports_top #(
        .PORT_W(W),
        .RST_EN(1'b1)
    ) dut (
        .ports_clk_i      (clk),
        .ports_rst_i      (rst),
        .ports_test_mode_i(tm),
        .bus              (bus)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    logic [7:0] s_en [4];
    logic [7:0] s_d  [5];
    logic [7:0] s_y  [4];

    // Model state: last pad sample (second sync stage) and expected read-back.
    logic [7:0] m_ylast [4];
    logic [7:0] m_rd    [4];

    typedef struct {
        logic [7:0] pen;
        logic [7:0] d;
        logic [7:0] d4;
        logic [7:0] y;
        logic       tmode;
        logic [7:0] exp_en;
        logic [7:0] exp_a;
        logic [7:0] exp_a4;
        logic [7:0] exp_rd;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %02h expected %02h", name, act, exp);
        end
    endtask

    task automatic apply();
        bus.ports_sfr_P0EN_i = s_en[0];
        bus.ports_sfr_P1EN_i = s_en[1];
        bus.ports_sfr_P2EN_i = s_en[2];
        bus.ports_sfr_P3EN_i = s_en[3];
        bus.ports_sfr_P0_i   = s_d[0];
        bus.ports_sfr_P1_i   = s_d[1];
        bus.ports_sfr_P2_i   = s_d[2];
        bus.ports_sfr_P3_i   = s_d[3];
        bus.ports_sfr_P4_i   = s_d[4];
        bus.y_port0_i        = s_y[0];
        bus.y_port1_i        = s_y[1];
        bus.y_port2_i        = s_y[2];
        bus.y_port3_i        = s_y[3];
    endtask

    function automatic logic [7:0] get_en(input int p);
        case (p)
            0:       return bus.en_port0_o;
            1:       return bus.en_port1_o;
            2:       return bus.en_port2_o;
            default: return bus.en_port3_o;
        endcase
    endfunction

    function automatic logic [7:0] get_a(input int p);
        case (p)
            0:       return bus.a_port0_o;
            1:       return bus.a_port1_o;
            2:       return bus.a_port2_o;
            3:       return bus.a_port3_o;
            default: return bus.a_port4_o;
        endcase
    endfunction

    function automatic logic [7:0] get_rd(input int p);
        case (p)
            0:       return bus.ports_sfr_P0_o;
            1:       return bus.ports_sfr_P1_o;
            2:       return bus.ports_sfr_P2_o;
            default: return bus.ports_sfr_P3_o;
        endcase
    endfunction

    // One rising edge; the model folds in the inputs present at that edge.
    task automatic clock();
        logic [7:0] en_eff;
        logic [7:0] ysrc;
        @(posedge clk);
        for (int p = 0; p < 4; p++) begin
            if (rst) begin
                m_rd[p]    = 8'h00;
                m_ylast[p] = 8'h00;
            end else begin
                en_eff = tm ? 8'hFF : ~s_en[p];
                ysrc   = (LAT == 2) ? m_ylast[p] : s_y[p];
                for (int n = 0; n < 8; n++) begin
                    m_rd[p][n] = en_eff[n] ? ysrc[n] : s_d[p][n];
                end
                m_ylast[p] = s_y[p];
            end
        end
        #1;
    endtask

    task automatic check_comb();
        logic ovr;
        ovr = rst | tm;
        for (int p = 0; p < 4; p++) begin
            check($sformatf("en%0d", p), get_en(p), ovr ? 8'hFF : ~s_en[p]);
        end
        for (int p = 0; p < 5; p++) begin
            check($sformatf("a%0d", p), get_a(p), ovr ? 8'h00 : s_d[p]);
        end
    endtask

    task automatic check_rd_model();
        for (int p = 0; p < 4; p++) begin
            check($sformatf("rd%0d", p), get_rd(p), m_rd[p]);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] one;
        one = 8'h01;

        //            pen    d      d4     y      tm    en     a      a4     rd
        vecs[0] = '{8'hA5, 8'h3C, 8'hC3, 8'h00, 1'b0, 8'h5A, 8'h3C, 8'hC3, 8'h24};
        vecs[1] = '{8'h00, 8'h3C, 8'hC3, 8'h96, 1'b0, 8'hFF, 8'h3C, 8'hC3, 8'h96};
        vecs[2] = '{8'hFF, 8'h55, 8'hAA, 8'h12, 1'b0, 8'h00, 8'h55, 8'hAA, 8'h55};
        vecs[3] = '{8'hFF, 8'h55, 8'hAA, 8'h6B, 1'b1, 8'hFF, 8'h00, 8'h00, 8'h6B};
        vecs[4] = '{8'h0F, 8'hFF, 8'h00, 8'h00, 1'b0, 8'hF0, 8'hFF, 8'h00, 8'h0F};
        vecs[5] = '{8'h3C, 8'h81, 8'h7E, 8'hC5, 1'b1, 8'hFF, 8'h00, 8'h00, 8'hC5};

        // Reset: override visible before any edge, read-back cleared by one edge.
        rst = 1'b1;
        tm  = 1'b0;
        for (int p = 0; p < 4; p++) begin
            s_en[p]    = 8'hA5;
            s_d[p]     = 8'h3C;
            s_y[p]     = 8'h77;
            m_ylast[p] = 8'h00;
            m_rd[p]    = 8'h00;
        end
        s_d[4] = 8'hC3;
        apply();
        #2;
        for (int p = 0; p < 4; p++) check($sformatf("rst_en%0d", p), get_en(p), 8'hFF);
        for (int p = 0; p < 5; p++) check($sformatf("rst_a%0d", p), get_a(p), 8'h00);
        clock();
        for (int p = 0; p < 4; p++) check($sformatf("rst_rd%0d", p), get_rd(p), 8'h00);
        rst = 1'b0;

        // Table vectors, same values on every port.
        for (int v = 0; v < 6; v++) begin
            for (int p = 0; p < 4; p++) begin
                s_en[p] = vecs[v].pen;
                s_d[p]  = vecs[v].d;
                s_y[p]  = vecs[v].y;
            end
            s_d[4] = vecs[v].d4;
            tm     = vecs[v].tmode;
            apply();
            #1;
            for (int p = 0; p < 4; p++) begin
                check($sformatf("vec%0d_en%0d", v, p), get_en(p), vecs[v].exp_en);
                check($sformatf("vec%0d_a%0d", v, p), get_a(p), vecs[v].exp_a);
            end
            check($sformatf("vec%0d_a4", v), get_a(4), vecs[v].exp_a4);
            for (int k = 0; k < LAT; k++) clock();
            for (int p = 0; p < 4; p++) begin
                check($sformatf("vec%0d_rd%0d", v, p), get_rd(p), vecs[v].exp_rd);
            end
        end
        tm = 1'b0;

        // Direction walk, no clock involved.
        for (int p = 0; p < 4; p++) begin
            for (int n = 0; n < 8; n++) begin
                for (int q = 0; q < 4; q++) s_en[q] = 8'h00;
                s_en[p] = one << n;
                apply();
                #1;
                check($sformatf("walk_p%0d_b%0d", p, n), get_en(p), ~(one << n));
            end
        end

        // Test mode asserts and releases in-cycle.
        for (int p = 0; p < 4; p++) begin
            s_en[p] = 8'hFF;
            s_d[p]  = 8'h5A;
        end
        apply();
        #1;
        check("tm_before_en0", get_en(0), 8'h00);
        tm = 1'b1;
        #1;
        check("tm_on_en2", get_en(2), 8'hFF);
        check("tm_on_a1", get_a(1), 8'h00);
        tm = 1'b0;
        #1;
        check("tm_off_en3", get_en(3), 8'h00);
        check("tm_off_a3", get_a(3), 8'h5A);

        // Pad latency on an input port.
        s_en[0] = 8'h00;
        s_y[0]  = 8'h00;
        apply();
        for (int k = 0; k < 3; k++) clock();
        check("lat_pre", get_rd(0), 8'h00);
        s_y[0] = 8'hFF;
        apply();
        clock();
        check("lat_edge1", get_rd(0), (LAT == 1) ? 8'hFF : 8'h00);
        clock();
        check("lat_edge2", get_rd(0), 8'hFF);

        // Direction change mid-stream: enable immediate, read-back source next edge.
        s_en[2] = 8'h00;
        s_d[2]  = 8'hA5;
        s_y[2]  = 8'h5A;
        apply();
        for (int k = 0; k < 3; k++) clock();
        check("dir_in_rd", get_rd(2), 8'h5A);
        s_en[2] = 8'hFF;
        apply();
        #1;
        check("dir_en_now", get_en(2), 8'h00);
        check("dir_rd_hold", get_rd(2), 8'h5A);
        clock();
        check("dir_rd_next", get_rd(2), 8'hA5);

        // Randomized run against the model.
        for (int i = 0; i < 1000; i++) begin
            for (int p = 0; p < 4; p++) begin
                s_en[p] = 8'($urandom);
                s_d[p]  = 8'($urandom);
                s_y[p]  = 8'($urandom);
            end
            s_d[4] = 8'($urandom);
            tm  = ($urandom_range(0, 9) == 0);
            rst = ($urandom_range(0, 49) == 0);
            apply();
            #1;
            check_comb();
            clock();
            check_rd_model();
        end
        rst = 1'b0;
        tm  = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
